// File: rtl/bp_pkg.sv
// Shared types, constants and helpers for the gshare fetch predictor.
package bp_pkg;

  // Core-wide widths and the trap vector, kept in step with the core constants header.
  localparam int DATA_WID = 32;
  localparam int REGS_WID = 5;
  localparam logic [DATA_WID-1:0] EXCP_ADDR = 32'h0000_8000;

  localparam int CTR_WID_MAX = 4;
  typedef logic [CTR_WID_MAX-1:0] ctr_t;

  typedef enum logic [1:0] {BK_SEQ, BK_JUMP, BK_COND} br_kind_e;

  function automatic ctr_t weak_nt(input int ctr_wid);
    return ctr_t'((1 << (ctr_wid - 1)) - 1);
  endfunction

  function automatic br_kind_e classify(input logic branch, input logic predict);
    return branch ? (predict ? BK_COND : BK_JUMP) : BK_SEQ;
  endfunction

  // Word-aligned PC bits folded with the zero-extended history, masked to the table size.
  function automatic logic [15:0] pht_index(input logic [DATA_WID-1:0] pc,
                                            input logic [15:0] ghr,
                                            input int bht_size);
    logic [DATA_WID-1:0] mask;
    mask = DATA_WID'((64'd1 << bht_size) - 64'd1);
    return 16'(((pc >> 2) ^ DATA_WID'(ghr)) & mask);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack with wrap-on-overflow and pointer/count restore.
module ras_stack #(
  parameter int RAS_SIZE = 3,
  parameter int DATA_WID = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                replace,
  input  logic                restore,
  input  logic [DATA_WID-1:0] wdata,
  input  logic [RAS_SIZE-1:0] restore_top,
  input  logic [RAS_SIZE:0]   restore_cnt,
  output logic [DATA_WID-1:0] top_data,
  output logic [RAS_SIZE-1:0] top,
  output logic [RAS_SIZE:0]   cnt
);
  localparam logic [RAS_SIZE:0] FULL = {1'b1, {RAS_SIZE{1'b0}}};

  logic [DATA_WID-1:0] mem [1 << RAS_SIZE];
  logic [RAS_SIZE-1:0] top_q;
  logic [RAS_SIZE:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (restore) begin
      top_q <= restore_top;
      cnt_q <= restore_cnt;
    end else if (push) begin
      top_q <= top_q + RAS_SIZE'(1);
      if (cnt_q != FULL) cnt_q <= cnt_q + (RAS_SIZE+1)'(1);
    end else if (pop && cnt_q != '0) begin
      top_q <= top_q - RAS_SIZE'(1);
      cnt_q <= cnt_q - (RAS_SIZE+1)'(1);
    end
  end

  // Entry contents are data only: never reset and never rolled back on repair.
  always_ff @(posedge clk) begin
    if (!restore) begin
      if (push) mem[top_q + RAS_SIZE'(1)] <= wdata;
      else if (replace) mem[top_q] <= wdata;
    end
  end

  assign top_data = mem[top_q];
  assign top      = top_q;
  assign cnt      = cnt_q;

endmodule

// File: rtl/gshare_predictor.sv
// Fetch-stage next-PC predictor: gshare PHT plus return address stack, with EX-driven repair.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int BHT_SIZE = 8,
  parameter int GHR_LEN  = 6,
  parameter int CTR_WID  = 2,
  parameter int RAS_SIZE = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branch,
  input  logic                predict,
  input  logic                excp,
  input  logic                sret,
  input  logic [REGS_WID-1:0] rs1,
  input  logic [REGS_WID-1:0] rd,
  input  logic [DATA_WID-1:0] pc,
  input  logic [DATA_WID-1:0] imm,
  input  logic                upd_valid,
  input  logic [DATA_WID-1:0] upd_pc,
  input  logic [GHR_LEN-1:0]  upd_ghr,
  input  logic [RAS_SIZE-1:0] upd_ras_top,
  input  logic [RAS_SIZE:0]   upd_ras_cnt,
  input  logic                upd_predict,
  input  logic                upd_actual,
  input  logic [DATA_WID-1:0] upd_target,
  input  logic [DATA_WID-1:0] upd_predict_pc,
  output logic [DATA_WID-1:0] target_pc,
  output logic                predict_result,
  output logic                predict_fail,
  output logic [GHR_LEN-1:0]  pred_ghr,
  output logic [RAS_SIZE-1:0] pred_ras_top,
  output logic [RAS_SIZE:0]   pred_ras_cnt
);
  localparam int PHT_N = 1 << BHT_SIZE;
  localparam logic [CTR_WID-1:0] CTR_MAX = '1;
  localparam logic [CTR_WID-1:0] CTR_RST = CTR_WID'(weak_nt(CTR_WID));

  logic [CTR_WID-1:0]  pht [PHT_N];
  logic [GHR_LEN-1:0]  ghr;
  logic [DATA_WID-1:0] sepc;
  logic                start;
  br_kind_e            kind;
  logic [BHT_SIZE-1:0] rd_idx, up_idx;
  logic                cond_taken, is_ret, is_push, is_repl, ras_en, ras_restore;
  logic [DATA_WID-1:0] pc_seq, pc_jmp, ras_data;
  logic [RAS_SIZE-1:0] ras_top;
  logic [RAS_SIZE:0]   ras_cnt;

  function automatic logic [CTR_WID-1:0] sat_step(input logic [CTR_WID-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_WID'(1);
    return (c == '0) ? c : c - CTR_WID'(1);
  endfunction

  assign kind       = classify(branch, predict);
  assign rd_idx     = BHT_SIZE'(pht_index(pc, 16'(ghr), BHT_SIZE));
  assign up_idx     = BHT_SIZE'(pht_index(upd_pc, 16'(upd_ghr), BHT_SIZE));
  assign cond_taken = pht[rd_idx][CTR_WID-1];
  assign pc_seq     = pc + DATA_WID'(4);
  assign pc_jmp     = pc + imm;
  assign is_ret     = (rs1 == REGS_WID'(1)) && (rd != REGS_WID'(1));
  assign is_push    = (rd == REGS_WID'(1)) && (rs1 != REGS_WID'(1));
  assign is_repl    = (rd == REGS_WID'(1)) && (rs1 == REGS_WID'(1));

  assign predict_fail = upd_valid && (upd_predict != upd_actual) && (upd_predict_pc != upd_target);

  always_comb begin
    target_pc      = pc_seq;
    predict_result = 1'b0;
    if (excp) target_pc = sret ? sepc : EXCP_ADDR;
    else if (!start) target_pc = '0;
    else if (predict_fail) target_pc = upd_target;
    else if (kind == BK_COND) target_pc = cond_taken ? pc_jmp : pc_seq;
    else if (kind == BK_JUMP) target_pc = (is_ret && ras_cnt != '0) ? ras_data : pc_jmp;

    if (!start) predict_result = 1'b0;
    else if (predict_fail) predict_result = upd_actual;
    else if (kind == BK_JUMP) predict_result = 1'b1;
    else if (kind == BK_COND) predict_result = cond_taken;
  end

  assign pred_ghr     = ghr;
  assign pred_ras_top = ras_top;
  assign pred_ras_cnt = ras_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr   <= '0;
      sepc  <= '0;
      start <= 1'b0;
    end else begin
      start <= 1'b1;
      if (excp && !sret) sepc <= pc_seq;
      if (!stall) begin
        if (predict_fail) ghr <= GHR_LEN'({upd_ghr, upd_actual});
        else if (kind == BK_COND) ghr <= GHR_LEN'({ghr, predict_result});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= CTR_RST;
    end else if (upd_valid && !stall) begin
      pht[up_idx] <= sat_step(pht[up_idx], upd_actual);
    end
  end

  // The fetch before start is bogus, so it must not touch the stack.
  assign ras_en      = (kind == BK_JUMP) && !stall && !predict_fail && start;
  assign ras_restore = predict_fail && !stall;

  ras_stack #(.RAS_SIZE(RAS_SIZE), .DATA_WID(DATA_WID)) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (ras_en && is_push),
    .pop         (ras_en && is_ret),
    .replace     (ras_en && is_repl),
    .restore     (ras_restore),
    .wdata       (pc_seq),
    .restore_top (upd_ras_top),
    .restore_cnt (upd_ras_cnt),
    .top_data    (ras_data),
    .top         (ras_top),
    .cnt         (ras_cnt)
  );

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised next-generation fetch-stage predictor. It combines a gshare pattern history table (n-bit saturating counters indexed by PC XOR speculative global history) with a return address stack that tracks overflow and underflow. Both history and RAS state are checkpointed on every prediction and repaired on mispredict. It sits in IF, drives the next PC each cycle, and receives resolved-branch feedback from EX.

## Interface
- BHT_SIZE, 8, log2 of PHT entries; index = pc[BHT_SIZE+1:2] ^ zero-extended GHR
- GHR_LEN, 6, global history bits; legal range 1..BHT_SIZE
- CTR_WID, 2, counter width; legal range 1..4
- RAS_SIZE, 3, log2 of RAS depth
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  freezes all speculative state and table updates
- branch, predict  in  1 each  {1,0} = jal/jalr; {1,1} = conditional branch; otherwise sequential
- excp, sret  in  1 each  ecall redirect; sret returns to sepc
- rs1, rd  in  REGS_WID  source and destination register of the fetched jump
- pc, imm  in  DATA_WID  fetch PC and decoded immediate
- upd_valid  in  1  EX resolved a conditional branch this cycle
- upd_pc  in  DATA_WID  PC of the resolved branch
- upd_ghr  in  GHR_LEN  checkpointed GHR that travelled with that branch
- upd_ras_top  in  RAS_SIZE  checkpointed RAS pointer
- upd_ras_cnt  in  RAS_SIZE+1  checkpointed RAS count
- upd_predict, upd_actual  in  1 each  predicted and actual direction
- upd_target, upd_predict_pc  in  DATA_WID  correct next PC, and next PC that was predicted
- target_pc  out  DATA_WID  next fetch PC
- predict_result  out  1  predicted taken
- predict_fail  out  1  redirect and flush request
- pred_ghr  out  GHR_LEN  GHR value used for this fetch
- pred_ras_top  out  RAS_SIZE  RAS pointer snapshot for this fetch
- pred_ras_cnt  out  RAS_SIZE+1  RAS count snapshot for this fetch

## Operation
- **Mispredict detection:** predict_fail = upd_valid & (upd_predict != upd_actual) & (upd_predict_pc != upd_target).
- **target_pc selection, in priority order:**
  - excp: sret ? sepc : EXCP_ADDR.
  - !start: 0.
  - predict_fail: upd_target.
  - Conditional branch: taken when ctr[idx] >= 2^(CTR_WID-1); target pc+imm when taken, else pc+4.
  - jal/jalr: RAS top when rs1==1 and rd!=1 and cnt>0; otherwise pc+imm.
  - Otherwise: pc+4.
- **predict_result:** 1 for any jump, the counter MSB for a conditional branch, 0 otherwise; on predict_fail it equals upd_actual.
- **sepc:** set to pc+4 on excp & !sret.
- **PHT update:** when upd_valid & !stall, entry (upd_pc idx ^ upd_ghr) counts up on taken and down on not-taken. Counters saturate at 0 and 2^CTR_WID-1.
- **GHR:**
  - On predict_fail: GHR <= {upd_ghr[GHR_LEN-2:0], upd_actual}.
  - Else on a conditional branch & !stall: GHR <= {GHR[GHR_LEN-2:0], predict_result}.
  - Otherwise it holds.
- **RAS:** updated on jal/jalr & !stall & !predict_fail.
  - Push (rd==1, rs1!=1): top+1 gets pc+4; cnt saturates at 2^RAS_SIZE; when full, the oldest entry is overwritten by wrap-around.
  - Pop (rs1==1, rd!=1): top-1 and cnt-1 when cnt>0; no change when cnt==0.
  - Pop-push (rd==1, rs1==1): entry[top] <= pc+4; top and cnt unchanged.
- **RAS repair:** on predict_fail, top <= upd_ras_top and cnt <= upd_ras_cnt. RAS entry contents are never restored.

## Timing
- Prediction is combinational from pc, rs1, rd and the registered state. Zero-cycle latency.
- Updates land at the next posedge. An update to the same PHT index that is read in the same cycle returns the old value; there is no bypass.
- Reset (asynchronous assert, synchronous deassert assumed from the reset tree):
  - All counters = 2^(CTR_WID-1)-1 (weakly not-taken).
  - GHR=0, top=0, cnt=0, sepc=0, start=0.
  - Outputs: target_pc=0, predict_result=0, predict_fail reflects the inputs, pred_* = 0.
- start rises at the first posedge after release. A reset asserted mid-operation clears state immediately.
- stall with predict_fail: the redirect is still output, but GHR, RAS and PHT are not written. EX must hold its upd_* values until the stall clears.

## Structure
- bp_pkg:
  - ctr_t width
  - weak-not-taken reset constant
  - branch-kind enum {SEQ, JUMP, COND}
  - index function
- EXCP_ADDR, DATA_WID and REGS_WID come from Const.svh.
- Sub-module ras_stack: circular array with top and cnt, push/pop/replace/restore ports.

## Test plan
- Reset, release, pc=0x100: target 0x0 in cycle 0, then 0x104; all pred_* = 0.
- Conditional branch at 0x200, imm=0x40, resolved taken twice with GHR=0: third fetch (with GHR=0) predicts taken, target 0x240.
- Two branches at the same PC with different GHR (000011 vs 000000) train to opposite directions and are predicted independently.
- RAS_SIZE=3: 9 pushes of jal ra, then 9 returns. The first 8 return correct addresses newest-first; the 9th returns pc+imm with cnt=0.
- Predicted not-taken branch resolves taken (upd_target=0x300) while a jal is fetched: target 0x300, GHR ends with a 1, RAS restored to upd_ras_top, jal push suppressed.
- excp at pc=0x80, then sret: target EXCP_ADDR, then 0x84; predict_fail pending at the same time is overridden.
